// File: rtl/muldiv_seq.sv
// HI/LO sequencer for MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// Owns HI/LO. Multiply commits after MUL_LAT edges. Divide uses 32 restoring steps plus one sign-fix edge.
module muldiv_seq #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        req_ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  // The accept edge counts as the first of the MUL_LAT edges, so the MUL state holds for MUL_LAT-1 cycles.
  localparam logic [4:0] MUL_CNT0 = (MUL_LAT > 1) ? 5'(MUL_LAT - 2) : 5'd0;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] op_a, op_b;
  logic        op_sgn;
  logic [31:0] a_raw, dvs, quo, rem;
  logic        q_neg, r_neg, div_zero;

  logic        accept, is_signed;
  logic [31:0] abs_a, abs_b;
  logic [31:0] mul_x, mul_y;
  logic        mul_s;
  logic [63:0] ext_x, ext_y, prod;
  logic [32:0] rem_sh;
  logic [33:0] diff;
  logic        unused_diff;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = req_valid && req_ready && !flush;
  assign is_signed = (req_op == OP_MULT) || (req_op == OP_DIV);

  assign abs_a = (is_signed && src_a[31]) ? (~src_a + 32'd1) : src_a;
  assign abs_b = (is_signed && src_b[31]) ? (~src_b + 32'd1) : src_b;

  // With MUL_LAT=1 the product is committed straight from the request operands.
  assign mul_x = (state == S_IDLE) ? src_a : op_a;
  assign mul_y = (state == S_IDLE) ? src_b : op_b;
  assign mul_s = (state == S_IDLE) ? is_signed : op_sgn;
  assign ext_x = {{32{mul_s & mul_x[31]}}, mul_x};
  assign ext_y = {{32{mul_s & mul_y[31]}}, mul_y};
  assign prod  = ext_x * ext_y;

  // Restoring step: the borrow bit of the trial subtract decides the quotient bit.
  assign rem_sh      = {rem, quo[31]};
  assign diff        = {1'b0, rem_sh} - {2'b00, dvs};
  assign unused_diff = diff[32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_sgn   <= 1'b0;
      a_raw    <= '0;
      dvs      <= '0;
      quo      <= '0;
      rem      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
    end else begin
      // NOTE: non-blocking everywhere here, so every branch reads the pre-edge state and the default below is simply overridden.
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (req_op)
              OP_MULT, OP_MULTU: begin
                op_a   <= src_a;
                op_b   <= src_b;
                op_sgn <= is_signed;
                if (MUL_LAT == 1) begin
                  hi_out <= prod[63:32];
                  lo_out <= prod[31:0];
                  done   <= 1'b1;
                end else begin
                  cnt   <= MUL_CNT0;
                  state <= S_MUL;
                end
              end
              OP_DIV, OP_DIVU: begin
                a_raw    <= src_a;
                quo      <= abs_a;
                dvs      <= abs_b;
                rem      <= '0;
                q_neg    <= is_signed & (src_a[31] ^ src_b[31]);
                r_neg    <= is_signed & src_a[31];
                div_zero <= (src_b == 32'd0);
                cnt      <= 5'd31;
                state    <= S_DIV;
              end
              OP_MTHI: hi_out <= src_a;
              OP_MTLO: lo_out <= src_a;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (cnt == 5'd0) begin
            hi_out <= prod[63:32];
            lo_out <= prod[31:0];
            done   <= 1'b1;
            state  <= S_IDLE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        S_DIV: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            rem <= diff[33] ? rem_sh[31:0] : diff[31:0];
            quo <= {quo[30:0], ~diff[33]};
            cnt <= cnt - 5'd1;
            if (cnt == 5'd0) state <= S_FIX;
          end
        end
        S_FIX: begin
          if (!flush) begin
            if (div_zero) begin
              hi_out <= a_raw;
              lo_out <= 32'hFFFF_FFFF;
            end else begin
              hi_out <= r_neg ? (~rem + 32'd1) : rem;
              lo_out <= q_neg ? (~quo + 32'd1) : quo;
            end
            done <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq (MUL_LAT=3).
// Expected values are hand-computed constants.
module tb_muldiv_seq;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        req_ready, busy, done;
  logic [31:0] hi_out, lo_out;

  int n_checks = 0;
  int n_fail   = 0;
  int bcyc;

  muldiv_seq #(.MUL_LAT(3)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .src_a(src_a), .src_b(src_b), .flush(flush), .req_ready(req_ready),
    .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents one op for a single edge; returns #1 after that edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic with_flush);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    src_a     = a;
    src_b     = b;
    flush     = with_flush;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 3'd0;
    flush     = 1'b0;
  endtask

  // Steps until done is seen, counting busy cycles; leaves the bench in the done cycle.
  task automatic run_to_commit(input string tag, input int max_cycles, output int busy_cycles);
    bit seen = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      if (busy) busy_cycles++;
      if (done) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_pulse_end(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_done_once"}, 32'(done), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #12 reset = 1'b0;
    #1;
    check("rst_hi", hi_out, 32'h0);
    check("rst_lo", lo_out, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);

    issue(OP_MTHI, 32'h1234_5678, 32'h0, 1'b0);
    check("mthi_hi", hi_out, 32'h1234_5678);
    check("mthi_busy", 32'(busy), 32'd0);
    check("mthi_done", 32'(done), 32'd0);
    issue(OP_MTLO, 32'h9ABC_DEF0, 32'h0, 1'b0);
    check("mtlo_lo", lo_out, 32'h9ABC_DEF0);
    check("mtlo_hi", hi_out, 32'h1234_5678);
    check("mtlo_busy", 32'(busy), 32'd0);
    check("mtlo_done", 32'(done), 32'd0);

    issue(OP_MTHI, 32'hDEAD_BEEF, 32'h0, 1'b1);
    check("idle_flush_hi", hi_out, 32'h1234_5678);

    issue(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
    run_to_commit("mult", 10, bcyc);
    check("mult_busy_cycles", 32'(bcyc), 32'd2);
    check("mult_hi", hi_out, 32'hFFFF_FFFF);
    check("mult_lo", lo_out, 32'hFFFF_FFFA);
    check_pulse_end("mult");

    issue(OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
    run_to_commit("multu", 10, bcyc);
    check("multu_hi", hi_out, 32'h0000_0002);
    check("multu_lo", lo_out, 32'hFFFF_FFFA);

    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_to_commit("mult_min", 10, bcyc);
    check("mult_min_hi", hi_out, 32'h4000_0000);
    check("mult_min_lo", lo_out, 32'h0000_0000);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_to_commit("div", 40, bcyc);
    check("div_busy_cycles", 32'(bcyc), 32'd33);
    check("div_lo", lo_out, 32'hFFFF_FFFD);
    check("div_hi", hi_out, 32'hFFFF_FFFF);
    check_pulse_end("div");

    issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
    run_to_commit("divu", 40, bcyc);
    check("divu_lo", lo_out, 32'd14);
    check("divu_hi", hi_out, 32'd2);

    issue(OP_DIVU, 32'h0000_1234, 32'd0, 1'b0);
    run_to_commit("divz", 40, bcyc);
    check("divz_busy_cycles", 32'(bcyc), 32'd33);
    check("divz_hi", hi_out, 32'h0000_1234);
    check("divz_lo", lo_out, 32'hFFFF_FFFF);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_to_commit("divovf", 40, bcyc);
    check("divovf_lo", lo_out, 32'h8000_0000);
    check("divovf_hi", hi_out, 32'h0000_0000);

    // Flush ten cycles into a divide: HI=0, LO=0x80000000 must survive.
    issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_mid_busy", 32'(busy), 32'd0);
    check("flush_mid_ready", 32'(req_ready), 32'd1);
    check("flush_mid_done", 32'(done), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("flush_mid_hi", hi_out, 32'h0000_0000);
    check("flush_mid_lo", lo_out, 32'h8000_0000);

    // Flush on the FIX cycle (the 33rd busy cycle).
    issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (32) @(posedge clk);
    #1;
    check("flush_fix_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_fix_busy", 32'(busy), 32'd0);
    check("flush_fix_done", 32'(done), 32'd0);
    check("flush_fix_hi", hi_out, 32'h0000_0000);
    check("flush_fix_lo", lo_out, 32'h8000_0000);

    // Asynchronous reset pulse mid-divide, away from any clock edge.
    issue(OP_DIV, 32'd1000, 32'd3, 1'b0);
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_hi", hi_out, 32'h0);
    check("areset_lo", lo_out, 32'h0);
    #2 reset = 1'b0;
    issue(OP_MULTU, 32'd3, 32'd5, 1'b0);
    run_to_commit("post_rst", 10, bcyc);
    check("post_rst_hi", hi_out, 32'h0);
    check("post_rst_lo", lo_out, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
